single_port_sync_ram: RTL and testbench

//  - Synchronous single-port RAM with one shared bidirectional data bus.
//  - Controlled by chip-select, write-enable and output-enable pins.
//  - Generic on-chip scratch storage; one access (read or write) per clock.

---
 rtl/spram_pkg.sv | 11 +
 rtl/spram_tristate.sv | 18 +
 rtl/single_port_sync_ram.sv | 80 ++++++++
 tb/tb_single_port_sync_ram.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// spram_pkg: default geometry shared by the single-port RAM and its bus driver.
//   SPRAM_ADDR_WIDTH - default address width in bits
//   SPRAM_DATA_WIDTH - default word width in bits
//   SPRAM_DEPTH      - default number of words (<= 2**SPRAM_ADDR_WIDTH)
package spram_pkg;

  localparam int unsigned SPRAM_ADDR_WIDTH = 4;
  localparam int unsigned SPRAM_DATA_WIDTH = 16;
  localparam int unsigned SPRAM_DEPTH      = 16;

endpackage : spram_pkg

// File: rtl/spram_tristate.sv
// spram_tristate: tri-state driver for the RAM's shared data pin.
// Ports:
//   en  - 1 drives din onto bus, 0 releases bus to high impedance
//   din - value to drive
//   bus - bidirectional data pin
module spram_tristate
  import spram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPRAM_DATA_WIDTH
) (
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  inout  logic [DATA_WIDTH-1:0] bus
);

  assign bus = en ? din : 'z;

endmodule : spram_tristate

// File: rtl/single_port_sync_ram.sv
// single_port_sync_ram: synchronous single-port RAM with a shared tri-state
// data bus, one read or write per clock, 1-cycle read latency.
// Ports:
//   clk   - clock, all state updates on posedge
//   rst_n - asynchronous active-low reset (clears read register, releases bus)
//   addr  - word address
//   cs    - chip select; no access when 0
//   we    - 1 = write, 0 = read (qualified by cs)
//   oe    - output enable for the read bus driver
//   data  - write data in / read data out (tri-state)
// Build option:
//   SPRAM_RESET_CLEAR_EN - when defined, every word is cleared to 0
//                          asynchronously while rst_n is low; when undefined
//                          the array is not reset and stays RAM-inferable.
module single_port_sync_ram
  import spram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SPRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SPRAM_DATA_WIDTH,
  parameter int unsigned DEPTH      = SPRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  inout  logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drive_en;

  // Extra bit keeps the compare valid when DEPTH == 2**ADDR_WIDTH.
  assign in_range = ({1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign wr_en    = cs & we & in_range;
  assign rd_en    = cs & ~we;
  // we has priority over oe so the RAM never fights the writer.
  assign drive_en = cs & oe & ~we & rst_n;

`ifdef SPRAM_RESET_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr] <= data;
    end
  end
`else
  // No reset on the array so it maps to RAM; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[addr] <= data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= in_range ? mem[addr] : '0;
    end
  end

  spram_tristate #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_data_drv (
    .en  (drive_en),
    .din (rd_q),
    .bus (data)
  );

endmodule : single_port_sync_ram

// File: tb/tb_single_port_sync_ram.sv
// tb_single_port_sync_ram: scoreboard bench for single_port_sync_ram.
// The data bus carries weak pull-ups, so a released bus reads as all ones.
module tb_single_port_sync_ram;
  import spram_pkg::*;

  localparam int unsigned AW    = SPRAM_ADDR_WIDTH;
  localparam int unsigned DW    = SPRAM_DATA_WIDTH;
  localparam int unsigned DEPTH = SPRAM_DEPTH;
  localparam logic [DW-1:0] BUS_Z = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          cs;
  logic          we;
  logic          oe;
  logic          tb_en;
  logic [DW-1:0] tb_drv;
  wire logic [DW-1:0] data;

  always #5 clk = ~clk;

  assign data = tb_en ? tb_drv : 'z;

  for (genvar i = 0; i < DW; i++) begin : g_pu
    pullup (data[i]);
  end

  single_port_sync_ram #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .cs    (cs),
    .we    (we),
    .oe    (oe),
    .data  (data)
  );

  typedef struct {
    string         tag;
    logic [DW-1:0] exp;
  } sb_t;

  sb_t           sb_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] m_rdq;
  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] bus_exp();
    if (rst_n && cs && oe && !we) return m_rdq;
    if (tb_en) return tb_drv;
    return BUS_Z;
  endfunction

  // Set inputs between edges; the bench drives the bus for every we=1 cycle.
  task automatic drive(input logic r, input logic c, input logic w,
                       input logic o, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    rst_n  = r;
    cs     = c;
    we     = w;
    oe     = o;
    addr   = a;
    tb_drv = d;
    tb_en  = w;
    if (!r) begin
      m_rdq = '0;
`ifdef SPRAM_RESET_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
    end
  endtask

  // Apply one clock edge to the model, queue the expected bus value, then
  // pop and compare it shortly after the DUT's edge.
  task automatic step(input string tag, input bit chk);
    if (rst_n && cs) begin
      if (we) begin
        if (int'(addr) < DEPTH) model[addr] = tb_drv;
      end else begin
        m_rdq = (int'(addr) < DEPTH) ? model[addr] : '0;
      end
    end
    if (chk) sb_q.push_back('{tag: tag, exp: bus_exp()});
    @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check_eq(e.tag, data, e.exp);
    end
  endtask

  // Combinational look at the bus without a clock edge.
  task automatic peek(input string tag);
    #1;
    check_eq(tag, data, bus_exp());
  endtask

  initial begin
    m_rdq = '0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, AW'(3), '0);
    step("rst_bus0", 1'b1);
    step("rst_bus1", 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, AW'(3), '0);
    peek("rst_rdq");
`ifdef SPRAM_RESET_CLEAR_EN
    step("rst_clear_rd3", 1'b1);
`else
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step("idle_bus", 1'b1);
`endif

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, AW'(i), DW'(16'hA500 + i));
      step("wr_sweep", 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, AW'(i), '0);
      step($sformatf("rd_sweep%0d", i), 1'b1);
    end

    drive(1'b1, 1'b0, 1'b1, 1'b0, AW'(5), 16'hFFFF);
    step("cs0_wr", 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, AW'(5), '0);
    step("cs0_bus", 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, AW'(5), '0);
    step("cs0_mem5", 1'b1);

    drive(1'b1, 1'b1, 1'b0, 1'b0, AW'(2), '0);
    step("oe0_bus", 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, AW'(2), '0);
    peek("oe1_hold");
    step("oe1_rd", 1'b1);

    drive(1'b1, 1'b1, 1'b1, 1'b0, AW'(7), 16'h1234);
    step("b2b_wr", 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, AW'(7), '0);
    step("b2b_rd", 1'b1);

    drive(1'b0, 1'b1, 1'b1, 1'b0, AW'(9), 16'hBEEF);
    step("mrst_wr", 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, AW'(9), '0);
    step("mrst_bus", 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, AW'(9), '0);
    step("mrst_mem9", 1'b1);

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step("final_idle", 1'b1);

    if (sb_q.size() != 0) begin
      check_eq("sb_drain", DW'(sb_q.size()), '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_single_port_sync_ram
